// File: rtl/muldiv_sequencer_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
//   md_op_e    : funct3 encodings of the M-extension ops
//   md_state_e : sequencer FSM states
//   MD_XLEN    : operand/result width (also the iteration count)
package muldiv_pkg;

    localparam int MD_XLEN = 32;

    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } md_state_e;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Request/response bundle between the EX stage (master) and the mul/div unit (slave).
//   start_i  : launch an op; only looked at while the unit is IDLE
//   funct3_i : M-extension op select
//   op_a_i   : rs1 operand, op_b_i : rs2 operand
//   flush_i  : abort any in-flight op
//   busy_o   : stall request, high in CALC and DONE
//   done_o   : one-cycle pulse, result_o valid in that cycle
//   result_o : result, held until the next accepted start
//   state_o  : current FSM state, for debug/observation
// Handshake: a request is accepted on a rising edge where start_i=1, flush_i=0
// and busy_o=0; the response is the single cycle with done_o=1. There is no
// back-pressure on the response side.
interface muldiv_if
    import muldiv_pkg::*;
#(
    parameter int XLEN = MD_XLEN
);
    logic            start_i;
    logic [2:0]      funct3_i;
    logic [XLEN-1:0] op_a_i;
    logic [XLEN-1:0] op_b_i;
    logic            flush_i;
    logic            busy_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;
    md_state_e       state_o;

    modport master (
        output start_i, funct3_i, op_a_i, op_b_i, flush_i,
        input  busy_o, done_o, result_o, state_o
    );

    modport slave (
        input  start_i, funct3_i, op_a_i, op_b_i, flush_i,
        output busy_o, done_o, result_o, state_o
    );
endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration of the mul/div datapath, purely combinational.
//   is_div  : 0 = shift-add multiply step, 1 = restoring divide step
//   hi, lo  : accumulator halves (mul: {product_hi, multiplier/product_lo},
//             div: {remainder, dividend/quotient})
//   operand : multiplicand (mul) or divisor (div), unsigned magnitude
//   nxt_hi, nxt_lo : accumulator after this iteration
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic            is_div,
    input  logic [XLEN-1:0] hi,
    input  logic [XLEN-1:0] lo,
    input  logic [XLEN-1:0] operand,
    output logic [XLEN-1:0] nxt_hi,
    output logic [XLEN-1:0] nxt_lo
);
    logic [XLEN:0] sum;
    logic [XLEN:0] shifted_rem;
    logic [XLEN:0] diff;

    always_comb begin
        // Multiply: add multiplicand when the multiplier LSB is set; the carry
        // out becomes the new MSB of hi once everything shifts right by one.
        sum = {1'b0, hi} + (lo[0] ? {1'b0, operand} : '0);

        // Divide: remainder is always below the divisor, so the shifted value
        // fits in XLEN+1 bits and diff[XLEN] is a clean borrow flag.
        shifted_rem = {hi, lo[XLEN-1]};
        diff        = shifted_rem - {1'b0, operand};

        if (is_div) begin
            if (!diff[XLEN]) begin
                nxt_hi = diff[XLEN-1:0];
                nxt_lo = {lo[XLEN-2:0], 1'b1};
            end else begin
                nxt_hi = shifted_rem[XLEN-1:0];
                nxt_lo = {lo[XLEN-2:0], 1'b0};
            end
        end else begin
            nxt_hi = sum[XLEN:1];
            nxt_lo = {sum[0], lo[XLEN-1:1]};
        end
    end
endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit with its sequencing FSM.
// Operands are reduced to unsigned magnitudes on accept, XLEN radix-2
// iterations run in CALC, and the sign fix plus result select happen on the
// edge that enters DONE. Divide-by-zero and signed overflow skip CALC.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : muldiv_if slave modport (request, stall, result, debug state)
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int XLEN = MD_XLEN
) (
    input  logic       clk,
    input  logic       rst_n,
    muldiv_if.slave    bus
);
    localparam int CW = $clog2(XLEN + 1);

    md_state_e       state;
    md_op_e          op;
    logic [XLEN-1:0] acc_hi;
    logic [XLEN-1:0] acc_lo;
    logic [XLEN-1:0] operand;
    logic [CW-1:0]   count;
    logic            neg_res;
    logic            neg_rem;
    logic [XLEN-1:0] result;
    logic            busy;
    logic            done;

    // Accept-side decode
    md_op_e          op_in;
    logic            a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_zero, div_ovf, is_div_in, is_rem_in;
    logic [XLEN-1:0] fast_result;

    always_comb begin
        op_in     = md_op_e'(bus.funct3_i);
        is_div_in = bus.funct3_i[2];
        is_rem_in = bus.funct3_i[1];
        a_signed  = 1'b1;
        b_signed  = 1'b1;
        case (op_in)
            MD_MULHSU:                  b_signed = 1'b0;
            MD_MULHU, MD_DIVU, MD_REMU: begin
                a_signed = 1'b0;
                b_signed = 1'b0;
            end
            default: ;
        endcase
        a_neg = a_signed & bus.op_a_i[XLEN-1];
        b_neg = b_signed & bus.op_b_i[XLEN-1];
        // The most negative value negates to itself, which as an unsigned
        // magnitude is exactly right.
        a_mag = a_neg ? -bus.op_a_i : bus.op_a_i;
        b_mag = b_neg ? -bus.op_b_i : bus.op_b_i;

        div_zero = is_div_in && (bus.op_b_i == '0);
        div_ovf  = (op_in == MD_DIV || op_in == MD_REM)
                && (bus.op_a_i == {1'b1, {(XLEN-1){1'b0}}})
                && (bus.op_b_i == '1);

        fast_result = '0;
        if (div_zero)
            fast_result = is_rem_in ? bus.op_a_i : '1;
        else if (div_ovf)
            fast_result = is_rem_in ? '0 : bus.op_a_i;
    end

    // Datapath iteration
    logic [XLEN-1:0] nxt_hi, nxt_lo;

    muldiv_step #(.XLEN(XLEN)) u_step (
        .is_div  (op[2]),
        .hi      (acc_hi),
        .lo      (acc_lo),
        .operand (operand),
        .nxt_hi  (nxt_hi),
        .nxt_lo  (nxt_lo)
    );

    // Sign fix and result select, applied to the last iteration's output so
    // the result is registered on the same edge that enters DONE.
    logic [2*XLEN-1:0] product, prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_fix, fix_result;

    always_comb begin
        product  = {nxt_hi, nxt_lo};
        prod_fix = neg_res ? -product : product;
        quot_fix = neg_res ? -nxt_lo : nxt_lo;
        rem_fix  = neg_rem ? -nxt_hi : nxt_hi;
        case (op)
            MD_MUL:                       fix_result = prod_fix[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: fix_result = prod_fix[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:              fix_result = quot_fix;
            default:                      fix_result = rem_fix;
        endcase
    end

    // Sequencer FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            op      <= MD_MUL;
            acc_hi  <= '0;
            acc_lo  <= '0;
            operand <= '0;
            count   <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            result  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    // Flush has priority over a simultaneous start.
                    if (bus.start_i && !bus.flush_i) begin
                        op      <= op_in;
                        neg_res <= a_neg ^ b_neg;
                        neg_rem <= a_neg;
                        busy    <= 1'b1;
                        if (div_zero || div_ovf) begin
                            result <= fast_result;
                            done   <= 1'b1;
                            state  <= DONE;
                        end else begin
                            acc_hi  <= '0;
                            acc_lo  <= is_div_in ? a_mag : b_mag;
                            operand <= is_div_in ? b_mag : a_mag;
                            count   <= CW'(XLEN);
                            state   <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (bus.flush_i) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        acc_hi <= nxt_hi;
                        acc_lo <= nxt_lo;
                        count  <= count - 1'b1;
                        if (count == CW'(1)) begin
                            result <= fix_result;
                            done   <= 1'b1;
                            state  <= DONE;
                        end
                    end
                end
                DONE: begin
                    // Single-cycle state; a start seen here is dropped and a
                    // flush here lands in IDLE just the same.
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy_o   = busy;
    assign bus.done_o   = done;
    assign bus.result_o = result;
    assign bus.state_o  = state;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: hand-computed results, latency,
// busy window, flush, async reset and held-start behaviour.
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    // Clock / reset
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    muldiv_if bus_if ();

    muldiv_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    // Scoreboard
    logic [31:0] exp_q[$];
    int checks   = 0;
    int failures = 0;
    logic [31:0] last_res;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Drivers
    task automatic idle_inputs();
        bus_if.start_i  = 1'b0;
        bus_if.funct3_i = 3'b000;
        bus_if.op_a_i   = '0;
        bus_if.op_b_i   = '0;
        bus_if.flush_i  = 1'b0;
    endtask

    // Issue one op, wait for done_o, check result, latency and busy window.
    task automatic run_op(input string tag, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input int exp_lat);
        int lat;
        int busy_cyc;
        logic [31:0] exp;
        exp_q.push_back(exp_res);
        @(posedge clk); #1;
        bus_if.start_i  = 1'b1;
        bus_if.funct3_i = f3;
        bus_if.op_a_i   = a;
        bus_if.op_b_i   = b;
        lat      = 0;
        busy_cyc = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            bus_if.start_i = 1'b0;
            if (bus_if.busy_o) busy_cyc++;
            if (bus_if.done_o) begin
                lat = c;
                break;
            end
        end
        exp = exp_q.pop_front();
        check({tag, "_result"}, bus_if.result_o, exp);
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_busy_cycles"}, 32'(busy_cyc), 32'(exp_lat));
        last_res = exp;
        @(posedge clk); #1;
        check({tag, "_done_clear"}, 32'(bus_if.done_o), 32'd0);
        check({tag, "_busy_clear"}, 32'(bus_if.busy_o), 32'd0);
        check({tag, "_result_hold"}, bus_if.result_o, exp);
    endtask

    // Watchdog
    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Stimulus
    initial begin
        int dones;
        int done_at;
        rst_n = 1'b0;
        last_res = '0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy",   32'(bus_if.busy_o), 32'd0);
        check("reset_done",   32'(bus_if.done_o), 32'd0);
        check("reset_result", bus_if.result_o, 32'd0);
        check("reset_state",  32'(bus_if.state_o), 32'(IDLE));
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Multiplies
        run_op("mul_7_m3",      3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        run_op("mulhu_max",     3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        run_op("mulh_min_min",  3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
        run_op("mulhsu_m1_max", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
        run_op("mul_shift",     3'b000, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 33);

        // Divides
        run_op("div_m7_2",      3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        run_op("rem_m7_2",      3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        run_op("divu_100_7",    3'b101, 32'd100, 32'd7, 32'd14, 33);
        run_op("remu_100_7",    3'b111, 32'd100, 32'd7, 32'd2, 33);
        run_op("div_min_2",     3'b100, 32'h8000_0000, 32'd2, 32'hC000_0000, 33);

        // Fast paths
        run_op("divu_by0",      3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("div_by0",       3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("remu_by0",      3'b111, 32'h0000_1234, 32'd0, 32'h0000_1234, 1);
        run_op("rem_ovf",       3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
        run_op("div_ovf",       3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);

        // Flush mid-CALC when count reaches 10 (22 edges after the accept)
        @(posedge clk); #1;
        bus_if.start_i  = 1'b1;
        bus_if.funct3_i = 3'b101;
        bus_if.op_a_i   = 32'd100;
        bus_if.op_b_i   = 32'd7;
        dones = 0;
        @(posedge clk); #1;
        bus_if.start_i = 1'b0;
        repeat (22) begin
            @(posedge clk); #1;
            if (bus_if.done_o) dones++;
        end
        check("flush_inflight_busy", 32'(bus_if.busy_o), 32'd1);
        bus_if.flush_i = 1'b1;
        @(posedge clk); #1;
        bus_if.flush_i = 1'b0;
        check("flush_busy",   32'(bus_if.busy_o), 32'd0);
        check("flush_state",  32'(bus_if.state_o), 32'(IDLE));
        check("flush_result", bus_if.result_o, last_res);
        repeat (15) begin
            @(posedge clk); #1;
            if (bus_if.done_o) dones++;
        end
        check("flush_no_done", 32'(dones), 32'd0);
        run_op("divu_after_flush", 3'b101, 32'd100, 32'd7, 32'd14, 33);

        // Flush and start together in IDLE: nothing launches
        @(posedge clk); #1;
        bus_if.start_i  = 1'b1;
        bus_if.flush_i  = 1'b1;
        bus_if.funct3_i = 3'b000;
        bus_if.op_a_i   = 32'd3;
        bus_if.op_b_i   = 32'd3;
        @(posedge clk); #1;
        idle_inputs();
        check("flush_start_busy",  32'(bus_if.busy_o), 32'd0);
        check("flush_start_state", 32'(bus_if.state_o), 32'(IDLE));

        // start_i held through a multiply; operands change while busy
        @(posedge clk); #1;
        bus_if.start_i  = 1'b1;
        bus_if.funct3_i = 3'b000;
        bus_if.op_a_i   = 32'd7;
        bus_if.op_b_i   = 32'hFFFF_FFFD;
        dones   = 0;
        done_at = 0;
        for (int c = 1; c <= 34; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                bus_if.op_a_i = 32'd100;
                bus_if.op_b_i = 32'd100;
            end
            if (bus_if.done_o) begin
                dones++;
                done_at = c;
                check("held_result", bus_if.result_o, 32'hFFFF_FFEB);
            end
            if (c == 34) begin
                check("held_done_ignored_busy", 32'(bus_if.busy_o), 32'd0);
                bus_if.start_i = 1'b0;
            end
        end
        check("held_done_count", 32'(dones), 32'd1);
        check("held_done_cycle", 32'(done_at), 32'd33);

        // start_i held with a fast-path op: accept, DONE (start ignored), accept...
        @(posedge clk); #1;
        bus_if.start_i  = 1'b1;
        bus_if.funct3_i = 3'b101;
        bus_if.op_a_i   = 32'd9;
        bus_if.op_b_i   = 32'd0;
        dones = 0;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            check($sformatf("held_fast_done_c%0d", c), 32'(bus_if.done_o), 32'(c % 2));
            if (bus_if.done_o) dones++;
        end
        idle_inputs();
        check("held_fast_count", 32'(dones), 32'd3);
        repeat (2) @(posedge clk);

        // Asynchronous reset mid-CALC
        @(posedge clk); #1;
        bus_if.start_i  = 1'b1;
        bus_if.funct3_i = 3'b000;
        bus_if.op_a_i   = 32'd11;
        bus_if.op_b_i   = 32'd13;
        @(posedge clk); #1;
        idle_inputs();
        repeat (5) @(posedge clk);
        #1;
        check("pre_reset_busy", 32'(bus_if.busy_o), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_reset_busy",   32'(bus_if.busy_o), 32'd0);
        check("async_reset_done",   32'(bus_if.done_o), 32'd0);
        check("async_reset_result", bus_if.result_o, 32'd0);
        check("async_reset_state",  32'(bus_if.state_o), 32'(IDLE));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        dones = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus_if.done_o) dones++;
        end
        check("reset_no_done", 32'(dones), 32'd0);
        run_op("mul_after_reset", 3'b000, 32'd11, 32'd13, 32'd143, 33);

        // Final report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
